// File: rtl/qcore_ctrl_pipe_pkg.sv
// -----------------------------------------------------------------------------
// qcore_ctrl_pipe_pkg
// Shared QICK core pipeline definitions: the per-stage control word
// (CTRL_REG), the all-zero BUBBLE word, and the control FSM state
// encoding (PIPE_ST).
// -----------------------------------------------------------------------------
package qcore_ctrl_pipe_pkg;

   // Decoded control that travels with an instruction down the pipeline.
   typedef struct packed {
      logic [7:0] addr;       // destination / memory address
      logic       we;         // register file write enable
      logic       r_wave_we;  // wave register write enable
      logic [3:0] alu_op;     // ALU operation selector
      logic [4:0] dst;        // destination register index
   } CTRL_REG;

   // An empty slot: every enable is zero, so nothing downstream commits.
   localparam CTRL_REG BUBBLE = '0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL_RD = 2'd1,
      STALL_ID = 2'd2,
      HALT     = 2'd3
   } PIPE_ST;

   // Stage order: 0 = RD, 1 = X1, 2 = X2, 3 = WR
   localparam int NUM_STAGES = 4;
   localparam int ST_RD      = 0;
   localparam int ST_X1      = 1;
   localparam int ST_X2      = 2;
   localparam int ST_WR      = 3;

endpackage

// File: rtl/qcore_pipe_stage.sv
// -----------------------------------------------------------------------------
// qcore_pipe_stage
// One pipeline register holding a CTRL_REG control word.
//
// Ports:
//   clk_i   in   clock, rising edge
//   rst_i   in   asynchronous active-high reset, loads BUBBLE
//   hold_i  in   keep the current contents (wins over kill_i)
//   kill_i  in   load BUBBLE instead of d_i
//   d_i     in   control word from the previous stage
//   q_o     out  registered control word
// -----------------------------------------------------------------------------
module qcore_pipe_stage
   import qcore_ctrl_pipe_pkg::*;
(
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    hold_i,
   input  logic    kill_i,
   input  CTRL_REG d_i,
   output CTRL_REG q_o
);

   CTRL_REG stage_q;
   CTRL_REG stage_d;

   always_comb begin
      stage_d = stage_q;
      if (!hold_i) begin
         stage_d = kill_i ? BUBBLE : d_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stage_q <= BUBBLE;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q_o = stage_q;

endmodule

// File: rtl/qcore_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// qcore_ctrl_pipe
// Control-word pipeline RD -> X1 -> X2 -> WR for the QICK core, with halt,
// flush (taken jump) and hazard bubble handling plus optional statistics.
//
// Build option: define QICK_PIPE_STATS_EN to build the stall/bubble
// counters; otherwise stall_cnt_o/bubble_cnt_o are tied to zero.
//
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   asynchronous active-high reset
//   halt_i         in   freeze the whole pipeline
//   flush_i        in   taken jump, kills RD and X1 contents
//   id_reg_i       in   decoded control of the ID instruction
//   id_valid_i     in   id_reg_i holds a real instruction
//   bubble_id_i    in   hazard: bubble into RD
//   bubble_rd_i    in   hazard: hold RD, bubble into X1
//   rd_reg_o..wr_reg_o out  stage control words
//   id_stall_o     out  fetch/decode must hold its instruction
//   state_o        out  registered FSM state (PIPE_ST)
//   stall_cnt_o    out  saturating count of stall cycles (not halt)
//   bubble_cnt_o   out  saturating count of hazard bubble insertions
// -----------------------------------------------------------------------------
module qcore_ctrl_pipe
   import qcore_ctrl_pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             halt_i,
   input  logic             flush_i,
   input  CTRL_REG          id_reg_i,
   input  logic             id_valid_i,
   input  logic             bubble_id_i,
   input  logic             bubble_rd_i,
   output CTRL_REG          rd_reg_o,
   output CTRL_REG          x1_reg_o,
   output CTRL_REG          x2_reg_o,
   output CTRL_REG          wr_reg_o,
   output logic             id_stall_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] bubble_cnt_o
);

   PIPE_ST                  state_q;
   PIPE_ST                  state_d;
   logic [NUM_STAGES-1:0]   stage_hold;
   logic [NUM_STAGES-1:0]   stage_kill;
   CTRL_REG                 stage_din  [NUM_STAGES];
   CTRL_REG                 stage_dout [NUM_STAGES];
   logic                    id_stall_raw;

   // Request decode. Only the highest-priority request acts in a cycle,
   // which also makes the HALT exit honour a same-cycle flush.
   always_comb begin
      state_d      = RUN;
      stage_hold   = '0;
      stage_kill   = '0;
      id_stall_raw = 1'b0;
      if (halt_i) begin
         state_d      = HALT;
         stage_hold   = '1;
         id_stall_raw = 1'b1;
      end else if (flush_i) begin
         state_d           = RUN;
         stage_kill[ST_RD] = 1'b1;
         stage_kill[ST_X1] = 1'b1;
      end else if (bubble_rd_i) begin
         state_d           = STALL_RD;
         stage_hold[ST_RD] = 1'b1;
         stage_kill[ST_X1] = 1'b1;
         id_stall_raw      = 1'b1;
      end else if (bubble_id_i) begin
         state_d           = STALL_ID;
         stage_kill[ST_RD] = 1'b1;
         id_stall_raw      = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // An invalid ID slot enters RD as an empty slot.
   assign stage_din[ST_RD] = id_valid_i ? id_reg_i : BUBBLE;

   genvar gi;
   generate
      for (gi = 1; gi < NUM_STAGES; gi++) begin : g_chain
         assign stage_din[gi] = stage_dout[gi-1];
      end
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
         qcore_pipe_stage u_stage (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .hold_i (stage_hold[gi]),
            .kill_i (stage_kill[gi]),
            .d_i    (stage_din[gi]),
            .q_o    (stage_dout[gi])
         );
      end
   endgenerate

   assign rd_reg_o = stage_dout[ST_RD];
   assign x1_reg_o = stage_dout[ST_X1];
   assign x2_reg_o = stage_dout[ST_X2];
   assign wr_reg_o = stage_dout[ST_WR];
   assign state_o  = state_q;

   // The stall request is combinational from the inputs, so it is masked by
   // reset directly to stay low while reset is asserted.
   assign id_stall_o = id_stall_raw & ~rst_i;

`ifdef QICK_PIPE_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             stall_inc;
   logic             bubble_inc;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q;
   logic [CNT_W-1:0] bubble_cnt_d;

   // Halt cycles stall decode but are not counted as hazard stalls.
   assign stall_inc  = id_stall_raw & ~halt_i;
   // Exactly one bubble is inserted by whichever hazard request wins.
   assign bubble_inc = ~halt_i & ~flush_i & (bubble_rd_i | bubble_id_i);

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (bubble_inc && (bubble_cnt_q != CNT_MAX)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt_o  = stall_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`else
   assign stall_cnt_o  = '0;
   assign bubble_cnt_o = '0;
`endif

endmodule
